// File: rtl/decoder_nto2n_reg_if.sv
// rtl/decoder_nto2n_reg_if.sv - request/response bundle for decoder_nto2n_reg
interface decoder_nto2n_reg_if #(
  parameter int N = 3
);
  localparam int W = 1 << N;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] addr;
  logic         en;
  logic [1:0]   mode;
  logic         clr;
  logic [W-1:0] dout;
  logic         out_valid;
  logic         busy;

  modport master (
    output in_valid, addr, en, mode, clr,
    input  in_ready, dout, out_valid, busy
  );

  modport slave (
    input  in_valid, addr, en, mode, clr,
    output in_ready, dout, out_valid, busy
  );
endinterface

// File: rtl/decoder_nto2n_reg.sv
// rtl/decoder_nto2n_reg.sv - registered N-to-2^N decoder with handshake and output hold
module decoder_nto2n_reg #(
  parameter int N    = 3,
  parameter int HOLD = 1
) (
  input  logic                clk,
  input  logic                rst,
  decoder_nto2n_reg_if.slave  bus
);
  localparam int W  = 1 << N;
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [W-1:0]  ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_1 = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_H = CW'(HOLD);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          acc_q, acc_d;

  logic          in_ready;
  logic          accept;
  logic [W-1:0]  base;
  logic [W-1:0]  onehot;
  logic [W-1:0]  thermo;

  assign in_ready = (state_q == S_IDLE) || (cnt_q == CNT_1);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    acc_d   = acc_q;

    // clr lands before any new decode so accumulate starts from zero
    base   = bus.clr ? '0 : dout_q;
    onehot = ONE << bus.addr;
    thermo = onehot | (onehot - ONE);

    if (accept) begin
      state_d = S_HOLD;
      cnt_d   = CNT_H;
      acc_d   = (bus.mode == 2'b10);
      if (!bus.en) begin
        dout_d = (bus.mode == 2'b10) ? base : '0;
      end else begin
        case (bus.mode)
          2'b01:   dout_d = thermo;
          2'b10:   dout_d = base | onehot;
          default: dout_d = onehot;
        endcase
      end
    end else begin
      dout_d = base;
      if (state_q == S_HOLD) begin
        if (cnt_q == CNT_1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          // only accumulate results survive the end of the hold window
          if (!acc_q) dout_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.dout      = dout_q;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.busy      = (state_q == S_HOLD);
endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// tb/tb_decoder_nto2n_reg.sv - directed and randomized bench for decoder_nto2n_reg
module tb_decoder_nto2n_reg;
  localparam int HOLDA = 2;
  localparam int HOLDB = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  // reference model: remaining presentation cycles, current output, last request was accumulate
  int   m_left;
  int   m_dout;
  bit   m_acc;

  decoder_nto2n_reg_if #(.N(3)) ia ();
  decoder_nto2n_reg_if #(.N(3)) ib ();

  decoder_nto2n_reg #(.N(3), .HOLD(HOLDA)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  decoder_nto2n_reg #(.N(3), .HOLD(HOLDB)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input int ad, input bit e, input int m, input bit c);
    bit ready;
    int base;
    int oh;
    ia.in_valid = v;
    ia.addr     = 3'(ad);
    ia.en       = e;
    ia.mode     = 2'(m);
    ia.clr      = c;
    ready = (m_left <= 1);
    check("in_ready", ia.in_ready, ready);
    if (v && ready) begin
      base = c ? 0 : m_dout;
      oh   = 1 << ad;
      if (e) begin
        case (m)
          1:       m_dout = (1 << (ad + 1)) - 1;
          2:       m_dout = base | oh;
          default: m_dout = oh;
        endcase
      end else begin
        m_dout = (m == 2) ? base : 0;
      end
      m_left = HOLDA;
      m_acc  = (m == 2);
    end else begin
      if (c) m_dout = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0 && !m_acc) m_dout = 0;
      end
    end
    @(posedge clk);
    #1;
    check("dout", ia.dout, m_dout);
    check("out_valid", ia.out_valid, m_left > 0);
    check("busy", ia.busy, m_left > 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int ov_cnt;
    int acc_seen;
    clk = 0;
    rst = 1;
    tests = 0;
    fails = 0;
    m_left = 0;
    m_dout = 0;
    m_acc  = 0;
    ia.in_valid = 0; ia.addr = 0; ia.en = 0; ia.mode = 0; ia.clr = 0;
    ib.in_valid = 0; ib.addr = 0; ib.en = 0; ib.mode = 0; ib.clr = 0;

    #3;
    check("rst_dout", ia.dout, 8'h00);
    check("rst_out_valid", ia.out_valid, 1'b0);
    check("rst_busy", ia.busy, 1'b0);
    #9 rst = 0;
    #1;
    check("post_rst_in_ready", ia.in_ready, 1'b1);

    // HOLD=4 stall: request held high, accepts exactly every 4 cycles
    acc_seen = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      ib.in_valid = 1;
      ib.en       = 1;
      ib.addr     = 3'($urandom_range(0, 7));
      check("stall_in_ready", ib.in_ready, (cyc % HOLDB) == 0);
      if (ib.in_ready) acc_seen++;
      @(posedge clk);
      #1;
      check("stall_out_valid", ib.out_valid, 1'b1);
    end
    ib.in_valid = 0;
    check("stall_accepts", acc_seen, 5);
    for (int k = 0; k < HOLDB; k++) idle();
    for (int k = 0; k < HOLDB; k++) begin
      @(posedge clk);
      #1;
    end
    check("stall_idle", ib.busy, 1'b0);

    // one-hot sweep back-to-back
    ov_cnt = 0;
    for (int ad = 0; ad < 8; ad++) begin
      step(1, ad, 1, 0, 0);
      check("sweep_dout", ia.dout, 64'(1) << ad);
      if (ia.out_valid) ov_cnt++;
      idle();
      if (ia.out_valid) ov_cnt++;
    end
    check("sweep_ov_run", ov_cnt, 16);
    idle();
    check("sweep_exit_dout", ia.dout, 8'h00);

    // enable off, then on
    step(1, 3, 0, 0, 0);
    check("en0_dout", ia.dout, 8'h00);
    check("en0_ov", ia.out_valid, 1'b1);
    idle();
    idle();
    step(1, 3, 1, 0, 0);
    check("en1_dout", ia.dout, 8'h08);
    idle();
    idle();

    // thermometer
    step(1, 0, 1, 1, 0); check("thermo0", ia.dout, 8'h01); idle();
    step(1, 5, 1, 1, 0); check("thermo5", ia.dout, 8'h3F); idle();
    step(1, 7, 1, 1, 0); check("thermo7", ia.dout, 8'hFF); idle();
    idle();
    check("thermo_exit", ia.dout, 8'h00);

    // accumulate with idle gaps, then clr
    step(1, 1, 1, 2, 0); idle(); idle(); check("acc1", ia.dout, 8'h02);
    step(1, 4, 1, 2, 0); idle(); idle(); check("acc4", ia.dout, 8'h12);
    step(1, 6, 1, 2, 0); idle(); idle(); check("acc6", ia.dout, 8'h52);
    check("acc_idle_ov", ia.out_valid, 1'b0);
    step(1, 0, 0, 2, 0); check("acc_en0", ia.dout, 8'h52); idle(); idle();
    step(0, 0, 0, 0, 1); check("clr_alone", ia.dout, 8'h00);
    step(1, 1, 1, 2, 0); idle(); idle();
    step(1, 7, 1, 2, 1); check("clr_accept", ia.dout, 8'h80); idle(); idle();

    // asynchronous reset during HOLD
    step(1, 3, 1, 0, 0);
    check("pre_rst_dout", ia.dout, 8'h08);
    #2 rst = 1;
    #1;
    check("async_rst_dout", ia.dout, 8'h00);
    check("async_rst_ov", ia.out_valid, 1'b0);
    check("async_rst_busy", ia.busy, 1'b0);
    @(negedge clk);
    rst = 0;
    m_left = 0;
    m_dout = 0;
    m_acc  = 0;

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
